// File: rtl/dbus_ctrl_pkg.sv
// Shared types for the data-bus controller: access sizes, byte strobes and
// the data-bus request/response bundles.
package dbus_ctrl_pkg;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef logic [7:0] strobe_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        strobe_t     strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    function automatic logic is_misaligned(input msize_t size, input logic [2:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (size)
            MSIZE2:  mis = addr_lo[0];
            MSIZE4:  mis = |addr_lo[1:0];
            MSIZE8:  mis = |addr_lo;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dbus_ctrl_store_align.sv
// Combinational store lane steering: places right-justified write data on its
// byte lane within the 64-bit bus and builds the matching byte strobe.
module store_align
    import dbus_ctrl_pkg::*;
(
    input  logic [2:0]  addr_lo,
    input  msize_t      msize,
    input  logic [63:0] wdata,
    output logic [63:0] data,
    output strobe_t     strobe
);

    logic [2:0]  lane;
    logic [63:0] base_data;
    strobe_t     base_strb;

    always_comb begin
        lane      = 3'd0;
        base_data = wdata;
        base_strb = 8'hFF;
        case (msize)
            MSIZE1: begin
                lane      = addr_lo;
                base_data = {56'd0, wdata[7:0]};
                base_strb = 8'h01;
            end
            MSIZE2: begin
                lane      = {addr_lo[2:1], 1'b0};
                base_data = {48'd0, wdata[15:0]};
                base_strb = 8'h03;
            end
            MSIZE4: begin
                lane      = {addr_lo[2], 2'b00};
                base_data = {32'd0, wdata[31:0]};
                base_strb = 8'h0F;
            end
            default: begin
                lane      = 3'd0;
                base_data = wdata;
                base_strb = 8'hFF;
            end
        endcase
        data   = base_data << {lane, 3'b000};
        strobe = base_strb << lane;
    end

endmodule

// File: rtl/dbus_ctrl.sv
// Memory-stage data-bus controller: accepts one load/store at a time, runs the
// address/data handshake on the data bus and returns an extended load result.
//
// state | meaning
// IDLE  | ready for a new access
// REQ   | dreq_valid high, waiting for addr_ok
// WAIT  | address taken, waiting for data_ok
// DRAIN | access squashed after addr_ok; absorb data_ok silently
// RESP  | one-cycle completion (or misalignment error) pulse
module dbus_ctrl
    import dbus_ctrl_pkg::*;
#(
    parameter bit MISALIGN_CHK = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic        req_store,
    input  logic [63:0] req_addr,
    input  msize_t      req_msize,
    input  logic        req_sext,
    input  logic [63:0] req_wdata,
    input  logic        flush,
    output logic        req_ready,
    output logic        stall,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_misalign,
    output logic        dreq_valid,
    output logic [63:0] dreq_addr,
    output msize_t      dreq_size,
    output strobe_t     dreq_strobe,
    output logic [63:0] dreq_data,
    input  logic        dresp_addr_ok,
    input  logic        dresp_data_ok,
    input  logic [63:0] dresp_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DRAIN,
        S_RESP
    } state_t;

    state_t      state, state_nxt;
    logic [63:0] addr_q, data_q, rdata_q;
    msize_t      size_q;
    strobe_t     strb_q;
    logic        store_q, sext_q, err_q;
    logic [63:0] al_data;
    strobe_t     al_strb;
    logic        mis;
    dbus_req_t   dreq;
    dbus_resp_t  dresp;

    store_align u_store_align (
        .addr_lo (req_addr[2:0]),
        .msize   (req_msize),
        .wdata   (req_wdata),
        .data    (al_data),
        .strobe  (al_strb)
    );

    assign mis   = MISALIGN_CHK && is_misaligned(req_msize, req_addr[2:0]);
    assign dresp = '{addr_ok: dresp_addr_ok, data_ok: dresp_data_ok, data: dresp_data};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            size_q  <= MSIZE1;
            store_q <= 1'b0;
            sext_q  <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
            strb_q  <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && req_ready) begin
                addr_q  <= req_addr;
                size_q  <= req_msize;
                store_q <= req_store;
                sext_q  <= req_sext;
                err_q   <= mis;
                data_q  <= req_store ? al_data : 64'd0;
                strb_q  <= req_store ? al_strb : 8'h00;
                rdata_q <= '0;
            end else if ((state == S_REQ && dresp.addr_ok && dresp.data_ok) ||
                         (state == S_WAIT && dresp.data_ok)) begin
                rdata_q <= dresp.data;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = req_valid & ~flush;
                if (req_ready)
                    state_nxt = mis ? S_RESP : S_REQ;
            end
            S_REQ: begin
                // once addr_ok is seen the bus owes us data_ok, so a flush only
                // decides whether the result is reported
                if (dresp.addr_ok && dresp.data_ok)
                    state_nxt = flush ? S_IDLE : S_RESP;
                else if (dresp.addr_ok)
                    state_nxt = flush ? S_DRAIN : S_WAIT;
                else if (flush)
                    state_nxt = S_IDLE;
            end
            S_WAIT: begin
                if (dresp.data_ok)
                    state_nxt = flush ? S_IDLE : S_RESP;
                else if (flush)
                    state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (dresp.data_ok)
                    state_nxt = S_IDLE;
            end
            S_RESP: begin
                resp_valid = ~flush;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign dreq = '{valid: (state == S_REQ), addr: addr_q, size: size_q,
                    strobe: strb_q, data: data_q};

    assign dreq_valid  = dreq.valid;
    assign dreq_addr   = dreq.addr;
    assign dreq_size   = dreq.size;
    assign dreq_strobe = dreq.strobe;
    assign dreq_data   = dreq.data;

    assign stall         = req_valid & (state != S_RESP);
    assign resp_misalign = resp_valid & err_q;

    logic [63:0] shifted, ext;
    always_comb begin
        shifted = rdata_q >> {addr_q[2:0], 3'b000};
        case (size_q)
            MSIZE1:  ext = {{56{sext_q & shifted[7]}},  shifted[7:0]};
            MSIZE2:  ext = {{48{sext_q & shifted[15]}}, shifted[15:0]};
            MSIZE4:  ext = {{32{sext_q & shifted[31]}}, shifted[31:0]};
            default: ext = shifted;
        endcase
    end

    assign resp_rdata = (store_q | err_q) ? 64'd0 : ext;

endmodule

// File: tb/tb_dbus_ctrl.sv
// Directed bench for dbus_ctrl; responses are checked by a queue-driven monitor.
module tb_dbus_ctrl;
    import dbus_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid, req_store, req_sext, flush;
    logic [63:0] req_addr, req_wdata;
    msize_t      req_msize;
    logic        req_ready, stall, resp_valid, resp_misalign;
    logic [63:0] resp_rdata;
    logic        dreq_valid;
    logic [63:0] dreq_addr, dreq_data;
    msize_t      dreq_size;
    strobe_t     dreq_strobe;
    logic        dresp_addr_ok, dresp_data_ok;
    logic [63:0] dresp_data;

    always #5 clk = ~clk;

    dbus_ctrl #(.MISALIGN_CHK(1'b1)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .req_valid     (req_valid),
        .req_store     (req_store),
        .req_addr      (req_addr),
        .req_msize     (req_msize),
        .req_sext      (req_sext),
        .req_wdata     (req_wdata),
        .flush         (flush),
        .req_ready     (req_ready),
        .stall         (stall),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_misalign (resp_misalign),
        .dreq_valid    (dreq_valid),
        .dreq_addr     (dreq_addr),
        .dreq_size     (dreq_size),
        .dreq_strobe   (dreq_strobe),
        .dreq_data     (dreq_data),
        .dresp_addr_ok (dresp_addr_ok),
        .dresp_data_ok (dresp_data_ok),
        .dresp_data    (dresp_data)
    );

    typedef struct packed {
        logic [63:0] rdata;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (resetn === 1'b1 && resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_resp: got resp_valid rdata %h with no response pending", resp_rdata);
            end else begin
                e = exp_q.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_misalign", {63'd0, resp_misalign}, {63'd0, e.mis});
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req_valid     = 1'b0;
        req_store     = 1'b0;
        req_sext      = 1'b0;
        flush         = 1'b0;
        req_addr      = 64'd0;
        req_wdata     = 64'd0;
        req_msize     = MSIZE1;
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        dresp_data    = 64'd0;
    endtask

    task automatic issue(input logic st, input logic [63:0] a, input msize_t sz,
                         input logic sx, input logic [63:0] wd);
        req_valid = 1'b1;
        req_store = st;
        req_addr  = a;
        req_msize = sz;
        req_sext  = sx;
        req_wdata = wd;
    endtask

    // Store finishing with addr_ok+data_ok in its first REQ cycle.
    task automatic run_store(input logic [63:0] a, input msize_t sz, input logic [63:0] wd,
                             input strobe_t exp_strb, input logic [63:0] exp_data);
        next();
        issue(1'b1, a, sz, 1'b0, wd);
        exp_q.push_back('{rdata: 64'd0, mis: 1'b0});
        smp();
        chk("st_req_ready", {63'd0, req_ready}, 64'd1);
        next();
        req_valid     = 1'b0;
        req_wdata     = 64'hDEAD_DEAD_DEAD_DEAD;
        dresp_addr_ok = 1'b1;
        dresp_data_ok = 1'b1;
        smp();
        chk("st_dreq_valid", {63'd0, dreq_valid}, 64'd1);
        chk("st_dreq_addr", dreq_addr, a);
        chk("st_dreq_strobe", {56'd0, dreq_strobe}, {56'd0, exp_strb});
        chk("st_dreq_data", dreq_data, exp_data);
        next();
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        smp();
        chk("st_resp_cycle2", {63'd0, resp_valid}, 64'd1);
    endtask

    typedef struct {
        logic [63:0] addr;
        msize_t      size;
        logic [63:0] wdata;
        strobe_t     strb;
        logic [63:0] data;
    } st_vec_t;

    st_vec_t st_tab[4];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        st_tab[0] = '{64'h0000_0000_1000_0005, MSIZE1, 64'h0000_0000_0000_00AB, 8'h20, 64'h0000_AB00_0000_0000};
        st_tab[1] = '{64'h0000_0000_1000_0006, MSIZE2, 64'h0000_0000_FFFF_BEEF, 8'hC0, 64'hBEEF_0000_0000_0000};
        st_tab[2] = '{64'h0000_0000_1000_0008, MSIZE8, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0123_4567_89AB_CDEF};
        st_tab[3] = '{64'h0000_0000_1000_0003, MSIZE1, 64'hFFFF_FFFF_FFFF_FF5A, 8'h08, 64'h0000_0000_5A00_0000};

        idle_inputs();
        resetn = 1'b0;
        #23;
        smp();
        chk("rst_dreq_valid", {63'd0, dreq_valid}, 64'd0);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_resp_misalign", {63'd0, resp_misalign}, 64'd0);
        chk("rst_dreq_addr", dreq_addr, 64'd0);
        chk("rst_stall", {63'd0, stall}, 64'd0);
        resetn = 1'b1;

        // store lane steering, including garbage in the upper wdata bits
        foreach (st_tab[i])
            run_store(st_tab[i].addr, st_tab[i].size, st_tab[i].wdata, st_tab[i].strb, st_tab[i].data);

        // slow load: addr_ok at cycle 3, data_ok at cycle 6, sign-extended word
        next();
        issue(1'b0, 64'h0000_0000_2000_0004, MSIZE4, 1'b1, 64'h0);
        exp_q.push_back('{rdata: 64'hFFFF_FFFF_8000_0000, mis: 1'b0});
        smp();
        chk("ld4_req_ready", {63'd0, req_ready}, 64'd1);
        chk("ld4_stall_c0", {63'd0, stall}, 64'd1);
        for (int c = 1; c <= 3; c++) begin
            next();
            req_valid     = 1'b0;
            req_addr      = 64'hFFFF_0000_0000_0000 + 64'(c);
            req_msize     = MSIZE8;
            dresp_addr_ok = (c == 3);
            smp();
            chk("ld4_dreq_valid", {63'd0, dreq_valid}, 64'd1);
            chk("ld4_dreq_addr", dreq_addr, 64'h0000_0000_2000_0004);
            chk("ld4_dreq_size", {62'd0, dreq_size}, {62'd0, MSIZE4});
            chk("ld4_dreq_strobe", {56'd0, dreq_strobe}, 64'd0);
            chk("ld4_dreq_data", dreq_data, 64'd0);
        end
        for (int c = 4; c <= 6; c++) begin
            next();
            dresp_addr_ok = 1'b0;
            dresp_data_ok = (c == 6);
            dresp_data    = (c == 6) ? 64'h8000_0000_0000_0000 : 64'h1111_1111_1111_1111;
            smp();
            chk("ld4_wait_dreq_valid", {63'd0, dreq_valid}, 64'd0);
            chk("ld4_no_early_resp", {63'd0, resp_valid}, 64'd0);
        end
        next();
        dresp_data_ok = 1'b0;
        dresp_data    = 64'd0;
        smp();
        chk("ld4_resp_cycle7", {63'd0, resp_valid}, 64'd1);

        // misaligned doubleword: error at cycle 1, no bus traffic, stall drops
        next();
        issue(1'b0, 64'h0000_0000_2000_0004, MSIZE8, 1'b0, 64'h0);
        exp_q.push_back('{rdata: 64'd0, mis: 1'b1});
        smp();
        chk("mis8_req_ready", {63'd0, req_ready}, 64'd1);
        next();
        smp();
        chk("mis8_dreq_valid", {63'd0, dreq_valid}, 64'd0);
        chk("mis8_resp_cycle1", {63'd0, resp_valid}, 64'd1);
        chk("mis8_stall", {63'd0, stall}, 64'd0);
        chk("mis8_no_accept_in_resp", {63'd0, req_ready}, 64'd0);
        next();
        req_valid = 1'b0;
        smp();
        chk("mis8_dreq_after", {63'd0, dreq_valid}, 64'd0);

        // store squashed in REQ before addr_ok, then a misaligned halfword
        next();
        issue(1'b1, 64'h0000_0000_1000_000C, MSIZE4, 1'b0, 64'h0000_DEAD_1234_5678);
        smp();
        next();
        req_valid = 1'b0;
        flush     = 1'b1;
        smp();
        chk("fl_dreq_strobe", {56'd0, dreq_strobe}, 64'h0000_0000_0000_00F0);
        chk("fl_dreq_data", dreq_data, 64'h1234_5678_0000_0000);
        next();
        flush = 1'b0;
        issue(1'b0, 64'h0000_0000_3000_0001, MSIZE2, 1'b0, 64'h0);
        exp_q.push_back('{rdata: 64'd0, mis: 1'b1});
        smp();
        chk("fl_idle_req_ready", {63'd0, req_ready}, 64'd1);
        chk("fl_dreq_valid", {63'd0, dreq_valid}, 64'd0);
        next();
        req_valid = 1'b0;
        smp();
        chk("mis2_resp", {63'd0, resp_valid}, 64'd1);

        // flush in WAIT, data_ok two cycles later, then a fresh byte load
        next();
        issue(1'b0, 64'h0000_0000_3000_0003, MSIZE1, 1'b1, 64'h0);
        smp();
        next();
        req_valid     = 1'b0;
        dresp_addr_ok = 1'b1;
        smp();
        next();
        dresp_addr_ok = 1'b0;
        flush         = 1'b1;
        smp();
        next();
        flush     = 1'b0;
        req_valid = 1'b1;
        req_msize = MSIZE1;
        req_addr  = 64'h0000_0000_3000_0003;
        smp();
        chk("drain_req_ready", {63'd0, req_ready}, 64'd0);
        next();
        dresp_data_ok = 1'b1;
        dresp_data    = 64'h0000_0000_FF00_0000;
        smp();
        chk("drain_dataok_req_ready", {63'd0, req_ready}, 64'd0);
        next();
        dresp_data_ok = 1'b0;
        exp_q.push_back('{rdata: 64'hFFFF_FFFF_FFFF_FF80, mis: 1'b0});
        smp();
        chk("drain_ready_after", {63'd0, req_ready}, 64'd1);
        next();
        req_valid     = 1'b0;
        dresp_addr_ok = 1'b1;
        dresp_data_ok = 1'b1;
        dresp_data    = 64'h0000_0000_8000_0000;
        smp();
        next();
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        smp();
        chk("ld1_resp", {63'd0, resp_valid}, 64'd1);

        // reset pulse in REQ, stray data_ok, then a zero-extended halfword
        next();
        issue(1'b0, 64'h0000_0000_4000_0000, MSIZE8, 1'b0, 64'h0);
        smp();
        next();
        req_valid = 1'b0;
        smp();
        chk("pre_rst_dreq_valid", {63'd0, dreq_valid}, 64'd1);
        #1;
        resetn = 1'b0;
        #1;
        chk("rst_mid_dreq_valid", {63'd0, dreq_valid}, 64'd0);
        chk("rst_mid_dreq_addr", dreq_addr, 64'd0);
        #1;
        resetn = 1'b1;
        next();
        dresp_data_ok = 1'b1;
        dresp_data    = 64'h5555_5555_5555_5555;
        smp();
        chk("stray_dataok_resp", {63'd0, resp_valid}, 64'd0);
        chk("stray_dataok_dreq", {63'd0, dreq_valid}, 64'd0);
        next();
        dresp_data_ok = 1'b0;
        issue(1'b0, 64'h0000_0000_4000_0002, MSIZE2, 1'b0, 64'h0);
        exp_q.push_back('{rdata: 64'h0000_0000_0000_FFFF, mis: 1'b0});
        smp();
        chk("post_rst_req_ready", {63'd0, req_ready}, 64'd1);
        next();
        req_valid     = 1'b0;
        dresp_addr_ok = 1'b1;
        dresp_data_ok = 1'b1;
        dresp_data    = 64'h0000_0000_FFFF_0000;
        smp();
        chk("post_rst_dreq_addr", dreq_addr, 64'h0000_0000_4000_0002);
        next();
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        smp();
        chk("post_rst_resp", {63'd0, resp_valid}, 64'd1);

        next();
        smp();
        chk("pending_responses", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
